compute_clock_gate_ctrl: RTL and testbench

- Control-domain block that generates the active-low compute clock enable consumed by the clock distribution stage's glitchless gating buffer.
- Runs a compute epoch of a programmed number of compute cycles.
- Gates the compute clock while any core raises a pause request, and ungates after a settle delay.
- Counts delivered compute cycles and reports completion to the host-facing control logic.

---
 rtl/compute_clock_gate_ctrl_if.sv | 27 ++
 rtl/compute_clock_gate_ctrl.sv | 147 ++++++++++++++
 tb/tb_compute_clock_gate_ctrl.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/compute_clock_gate_ctrl_if.sv
// Control/status bundle between host-side epoch control and the clock gate controller.
// The master drives start/stop/budget/pause requests; the slave returns gate enable and epoch status.
interface compute_clock_gate_ctrl_if #(
    parameter int NUM_CORES = 16,
    parameter int COUNT_W   = 48
);
    logic                 start;
    logic [COUNT_W-1:0]   cycle_budget;
    logic                 stop;
    logic [NUM_CORES-1:0] pause_req;
    logic                 compute_clock_en_n;
    logic                 running;
    logic                 paused;
    logic                 done;
    logic [COUNT_W-1:0]   cycle_count;
    logic [COUNT_W-1:0]   paused_cycles;

    modport master (
        output start, cycle_budget, stop, pause_req,
        input  compute_clock_en_n, running, paused, done, cycle_count, paused_cycles
    );

    modport slave (
        input  start, cycle_budget, stop, pause_req,
        output compute_clock_en_n, running, paused, done, cycle_count, paused_cycles
    );
endinterface

// File: rtl/compute_clock_gate_ctrl.sv
// Compute clock gate controller: runs a budgeted epoch, gates on core pause requests, resumes after a settle delay.
// Latency: gate enable is a flop, changing one control_clock cycle after the causing input is sampled.
// Backpressure: none; start/stop are pulses, pause_req is a level. Stall stats built with CLOCK_GATE_STALL_STATS_EN.
module compute_clock_gate_ctrl #(
    parameter int NUM_CORES    = 16,
    parameter int COUNT_W      = 48,
    parameter int RESUME_DELAY = 2
) (
    input  logic                          control_clock,
    input  logic                          reset_n,
    compute_clock_gate_ctrl_if.slave      ctl
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RUN,
        ST_PAUSE,
        ST_RESUME,
        ST_DONE
    } state_e;

    localparam int                 DLY_W    = (RESUME_DELAY > 1) ? $clog2(RESUME_DELAY) : 1;
    localparam logic [DLY_W-1:0]   DLY_LOAD = DLY_W'((RESUME_DELAY > 0) ? RESUME_DELAY - 1 : 0);
    localparam logic [COUNT_W-1:0] CNT_MAX  = '1;

    state_e               state_q, state_d;
    logic                 en_n_q, en_n_d;
    logic [COUNT_W-1:0]   budget_q, budget_d;
    logic [COUNT_W-1:0]   cycle_cnt_q, cycle_cnt_d;
    logic [DLY_W-1:0]     dly_q, dly_d;
    logic [NUM_CORES-1:0] pause_vec;
    logic                 any_pause;
    logic                 exhaust;

    assign pause_vec = ctl.pause_req;
    assign any_pause = |pause_vec;
    // Budget 0 means unlimited, so exhaustion is never flagged for it.
    assign exhaust   = (budget_q != '0) && (cycle_cnt_q == (budget_q - COUNT_W'(1)));

    always_comb begin
        state_d     = state_q;
        budget_d    = budget_q;
        cycle_cnt_d = cycle_cnt_q;
        dly_d       = dly_q;
        unique case (state_q)
            ST_IDLE: begin
                if (ctl.start) begin
                    budget_d    = ctl.cycle_budget;
                    cycle_cnt_d = '0;
                    state_d     = any_pause ? ST_PAUSE : ST_RUN;
                end
            end
            ST_RUN: begin
                if (cycle_cnt_q != CNT_MAX) begin
                    cycle_cnt_d = cycle_cnt_q + COUNT_W'(1);
                end
                if (ctl.stop || exhaust) begin
                    state_d = ST_DONE;
                end else if (any_pause) begin
                    state_d = ST_PAUSE;
                end
            end
            ST_PAUSE: begin
                if (ctl.stop) begin
                    state_d = ST_DONE;
                end else if (!any_pause) begin
                    if (RESUME_DELAY == 0) begin
                        state_d = ST_RUN;
                    end else begin
                        state_d = ST_RESUME;
                        dly_d   = DLY_LOAD;
                    end
                end
            end
            ST_RESUME: begin
                // A fresh pause throws away the partial settle; the next release restarts it in full.
                if (ctl.stop) begin
                    state_d = ST_DONE;
                end else if (any_pause) begin
                    state_d = ST_PAUSE;
                end else if (dly_q == '0) begin
                    state_d = ST_RUN;
                end else begin
                    dly_d = dly_q - DLY_W'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        en_n_d = (state_d != ST_RUN);
    end

    always_ff @(posedge control_clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            en_n_q      <= 1'b1;
            budget_q    <= '0;
            cycle_cnt_q <= '0;
            dly_q       <= '0;
        end else begin
            state_q     <= state_d;
            en_n_q      <= en_n_d;
            budget_q    <= budget_d;
            cycle_cnt_q <= cycle_cnt_d;
            dly_q       <= dly_d;
        end
    end

`ifdef CLOCK_GATE_STALL_STATS_EN
    logic [COUNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic               start_acc;

    assign start_acc = (state_q == ST_IDLE) && ctl.start;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (start_acc) begin
            stall_cnt_d = '0;
        end else if (((state_q == ST_PAUSE) || (state_q == ST_RESUME)) && (stall_cnt_q != CNT_MAX)) begin
            stall_cnt_d = stall_cnt_q + COUNT_W'(1);
        end
    end

    always_ff @(posedge control_clock or negedge reset_n) begin
        if (!reset_n) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign ctl.paused_cycles = stall_cnt_q;
`else
    assign ctl.paused_cycles = '0;
`endif

    assign ctl.compute_clock_en_n = en_n_q;
    assign ctl.running            = state_q inside {ST_RUN, ST_PAUSE, ST_RESUME};
    assign ctl.paused             = state_q inside {ST_PAUSE, ST_RESUME};
    assign ctl.done               = (state_q == ST_DONE);
    assign ctl.cycle_count        = cycle_cnt_q;

endmodule

// File: tb/tb_compute_clock_gate_ctrl.sv
// Bench for compute_clock_gate_ctrl: directed epochs plus random traffic against an epoch-level model.
module tb_compute_clock_gate_ctrl;
    localparam int NC = 16;
    localparam int CW = 8;
    localparam int RD = 2;
    localparam int unsigned CMAX = (1 << CW) - 1;
`ifdef CLOCK_GATE_STALL_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    compute_clock_gate_ctrl_if #(.NUM_CORES(NC), .COUNT_W(CW)) bus ();

    compute_clock_gate_ctrl #(.NUM_CORES(NC), .COUNT_W(CW), .RESUME_DELAY(RD)) dut (
        .control_clock (clk),
        .reset_n       (rst_n),
        .ctl           (bus)
    );

    int total = 0;
    int bad   = 0;

    // Epoch model: an active epoch either computes, holds for a pause, or waits out a resume delay.
    bit          m_active, m_done, m_hold;
    int          m_resume;
    int unsigned m_budget, m_cnt, m_stall;

    always @(posedge clk or negedge rst_n) begin
        bit comp;
        bit anyp;
        if (!rst_n) begin
            m_active = 0; m_done = 0; m_hold = 0; m_resume = 0;
            m_budget = 0; m_cnt = 0; m_stall = 0;
        end else begin
            anyp = |bus.pause_req;
            if (m_done) begin
                m_done = 0;
            end else if (!m_active) begin
                if (bus.start) begin
                    m_active = 1; m_budget = bus.cycle_budget; m_cnt = 0; m_stall = 0;
                    m_hold = anyp; m_resume = 0;
                end
            end else begin
                comp = !m_hold && (m_resume == 0);
                if (comp) begin
                    if (m_cnt < CMAX) m_cnt++;
                end else begin
                    if (m_stall < CMAX) m_stall++;
                end
                if (bus.stop || (comp && m_budget != 0 && m_cnt == m_budget)) begin
                    m_active = 0; m_done = 1; m_hold = 0; m_resume = 0;
                end else if (comp) begin
                    m_hold = anyp;
                end else if (m_hold) begin
                    if (!anyp) begin m_hold = 0; m_resume = RD; end
                end else if (anyp) begin
                    m_hold = 1; m_resume = 0;
                end else begin
                    m_resume--;
                end
            end
        end
    end

    int low_cnt, low_run, max_low, gap_run, max_gap, done_cnt, lead, ncyc;
    bit seen_low, paused_seen;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic clr_mon();
        low_cnt = 0; low_run = 0; max_low = 0; gap_run = 0; max_gap = 0;
        done_cnt = 0; lead = -1; ncyc = 0; seen_low = 0; paused_seen = 0;
    endtask

    // One control cycle: sample and compare at the falling edge, return just after the next rising edge.
    task automatic step();
        logic [2*CW+3:0] exp_v, act_v;
        @(negedge clk);
        ncyc++;
        if (bus.compute_clock_en_n == 1'b0) begin
            low_cnt++; low_run++; gap_run = 0;
            if (low_run > max_low) max_low = low_run;
            if (!seen_low) begin seen_low = 1; lead = ncyc - 1; end
        end else begin
            low_run = 0;
            if (bus.running) begin
                gap_run++;
                if (gap_run > max_gap) max_gap = gap_run;
            end else begin
                gap_run = 0;
            end
        end
        if (bus.done) done_cnt++;
        if (bus.paused) paused_seen = 1;
        exp_v = {!(m_active && !m_hold && m_resume == 0), m_active,
                 m_active && (m_hold || m_resume > 0), m_done,
                 CW'(m_cnt), STATS ? CW'(m_stall) : CW'(0)};
        act_v = {bus.compute_clock_en_n, bus.running, bus.paused, bus.done,
                 bus.cycle_count, bus.paused_cycles};
        chk("cycle", act_v, exp_v);
        @(posedge clk);
        #1;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic run_until_done(input string nm, input int bound);
        int n;
        n = 0;
        while (done_cnt == 0 && n < bound) begin
            step();
            n++;
        end
        chk({nm, "_timeout"}, done_cnt == 0, 0);
        steps(2);
    endtask

    task automatic begin_epoch(input int budget, input logic [NC-1:0] pr);
        bus.start = 1'b1;
        bus.cycle_budget = CW'(budget);
        bus.pause_req = pr;
        clr_mon();
        step();
        bus.start = 1'b0;
    endtask

    initial begin
        logic [NC-1:0] pr;
        bus.start = 1'b0; bus.stop = 1'b0; bus.cycle_budget = '0; bus.pause_req = '0;
        clr_mon();
        #2 rst_n = 1'b0;
        #1;
        chk("rst_en_n", bus.compute_clock_en_n, 1);
        chk("rst_running", bus.running, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_count", bus.cycle_count, 0);
        chk("rst_stall", bus.paused_cycles, 0);
        steps(2);
        rst_n = 1'b1;
        steps(2);

        // Budget 5, no pauses.
        begin_epoch(5, '0);
        run_until_done("s1", 50);
        chk("s1_lead", lead, 1);
        chk("s1_low", low_cnt, 5);
        chk("s1_run", max_low, 5);
        chk("s1_done", done_cnt, 1);
        chk("s1_count", bus.cycle_count, 5);

        // Budget 10, core 3 pauses for 4 cycles after 3 compute cycles.
        begin_epoch(10, '0);
        steps(3);
        bus.pause_req[3] = 1'b1;
        steps(4);
        bus.pause_req = '0;
        run_until_done("s2", 100);
        chk("s2_low", low_cnt, 10);
        chk("s2_gap", max_gap, 4 + RD);
        chk("s2_count", bus.cycle_count, 10);
        chk("s2_stall", bus.paused_cycles, STATS ? 6 : 0);

        // Unlimited budget, stop after 20 compute cycles, start during DONE ignored.
        begin_epoch(0, '0);
        steps(19);
        bus.stop = 1'b1;
        step();
        bus.stop = 1'b0;
        bus.start = 1'b1;
        bus.cycle_budget = 8'd7;
        step();
        bus.start = 1'b0;
        steps(3);
        chk("s3_low", low_cnt, 20);
        chk("s3_run", max_low, 20);
        chk("s3_done", done_cnt, 1);
        chk("s3_count", bus.cycle_count, 20);
        chk("s3_idle", bus.running, 0);

        // Exhaustion wins over a pause raised on the last budgeted cycle.
        begin_epoch(3, '0);
        steps(2);
        bus.pause_req[0] = 1'b1;
        run_until_done("s4", 20);
        bus.pause_req = '0;
        chk("s4_paused", paused_seen, 0);
        chk("s4_count", bus.cycle_count, 3);
        chk("s4_low", low_cnt, 3);

        // Pause re-raised during the resume delay restarts the full delay.
        begin_epoch(0, '0);
        step();
        bus.pause_req[9] = 1'b1;
        steps(2);
        bus.pause_req = '0;
        step();
        bus.pause_req[9] = 1'b1;
        step();
        bus.pause_req = '0;
        steps(5);
        bus.stop = 1'b1;
        step();
        bus.stop = 1'b0;
        run_until_done("s5", 20);
        chk("s5_gap", max_gap, 6);
        chk("s5_count", bus.cycle_count, 5);
        chk("s5_stall", bus.paused_cycles, STATS ? 6 : 0);

        // Reset asserted mid-epoch clears everything without a clock edge.
        begin_epoch(0, '0);
        steps(5);
        #2 rst_n = 1'b0;
        #1;
        chk("s6_en_n", bus.compute_clock_en_n, 1);
        chk("s6_running", bus.running, 0);
        chk("s6_count", bus.cycle_count, 0);
        chk("s6_stall", bus.paused_cycles, 0);
        steps(2);
        rst_n = 1'b1;
        step();
        begin_epoch(4, '0);
        run_until_done("s6", 30);
        chk("s6_after", bus.cycle_count, 4);
        chk("s6_low", low_cnt, 4);

        // Counters saturate at all-ones.
        begin_epoch(0, 16'h0001);
        steps(300);
        bus.pause_req = '0;
        steps(300);
        bus.stop = 1'b1;
        step();
        bus.stop = 1'b0;
        run_until_done("s7", 10);
        chk("s7_count", bus.cycle_count, CMAX);
        chk("s7_stall", bus.paused_cycles, STATS ? CMAX : 0);

        // Random traffic.
        pr = '0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 5) == 0) begin
                pr = '0;
                if ($urandom_range(0, 1) == 1) pr[$urandom_range(0, NC - 1)] = 1'b1;
            end
            bus.pause_req    = pr;
            bus.start        = ($urandom_range(0, 9) == 0);
            bus.cycle_budget = CW'($urandom_range(0, 25));
            bus.stop         = ($urandom_range(0, 59) == 0);
            step();
        end
        bus.start = 1'b0; bus.stop = 1'b0; bus.pause_req = '0;
        steps(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
